// File: rtl/te_radio_seq_if.sv
// te_radio_seq_if: request/status bundle between the timing engine's request
// logic and the radio power-up sequencer.
//
//   radio_on_req  level request to power the radio          (master -> slave)
//   rx_req        level RX request                          (master -> slave)
//   tx_req        level TX request                          (master -> slave)
//   pll_settled   PLL lock indication                       (master -> slave)
//   pll_en        PLL enable                                (slave -> master)
//   radio_enable  radio enable                              (slave -> master)
//   radio_rx_en   RX enable                                 (slave -> master)
//   radio_tx_en   TX enable                                 (slave -> master)
//   busy          sequencer not idle                        (slave -> master)
//   err           loss of lock / PLL timeout trap           (slave -> master)
//   state_o[2:0]  current state encoding                    (slave -> master)
interface te_radio_seq_if;
  logic       radio_on_req;
  logic       rx_req;
  logic       tx_req;
  logic       pll_settled;
  logic       pll_en;
  logic       radio_enable;
  logic       radio_rx_en;
  logic       radio_tx_en;
  logic       busy;
  logic       err;
  logic [2:0] state_o;

  modport master (
    output radio_on_req, rx_req, tx_req, pll_settled,
    input  pll_en, radio_enable, radio_rx_en, radio_tx_en, busy, err, state_o
  );

  modport slave (
    input  radio_on_req, rx_req, tx_req, pll_settled,
    output pll_en, radio_enable, radio_rx_en, radio_tx_en, busy, err, state_o
  );
endinterface

// File: rtl/te_radio_seq.sv
// te_radio_seq: radio power-up sequencer. Enables the PLL, waits for lock
// (bounded by PLL_TO_CYCLES), applies a GUARD_CYCLES guard interval, enables
// the radio and grants it to TX or RX requests (TX wins a tie, no preemption).
// Dropping radio_on_req ramps down for RAMP_CYCLES; loss of lock or a PLL
// timeout traps in ERR until radio_on_req is released.
//
// Ports:
//   ck      clock
//   srst_n  synchronous active-low reset
//   bus     te_radio_seq_if.slave (requests in, enables/status out)
//
// Optional build macro TE_SEQ_PLL_SYNC_EN: pass pll_settled through a 2-flop
// synchronizer before use (adds 2 cycles to every lock reaction).
//
// All outputs are registered and decoded from the next state.
module te_radio_seq #(
  parameter int CNT_W         = 12,
  parameter int PLL_TO_CYCLES = 1024,
  parameter int GUARD_CYCLES  = 16,
  parameter int RAMP_CYCLES   = 8
) (
  input  logic          ck,
  input  logic          srst_n,
  te_radio_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PLL_WAIT = 3'd1;
  localparam logic [2:0] S_GUARD    = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_RX       = 3'd4;
  localparam logic [2:0] S_TX       = 3'd5;
  localparam logic [2:0] S_RAMP     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam logic [CNT_W-1:0] PLL_TO_LAST = CNT_W'(PLL_TO_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAMP_LAST   = CNT_W'(RAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             pll_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pll_en_q, pll_en_d;
  logic radio_enable_q, radio_enable_d;
  logic rx_en_q, rx_en_d;
  logic tx_en_q, tx_en_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  // ---------------------------------------------------------------------------
  // Lock indication conditioning
  // ---------------------------------------------------------------------------
`ifdef TE_SEQ_PLL_SYNC_EN
  logic [1:0] pll_sync_q;

  always_ff @(posedge ck) begin
    if (!srst_n) begin
      pll_sync_q <= '0;
    end else begin
      pll_sync_q <= {pll_sync_q[0], bus.pll_settled};
    end
  end

  assign pll_s = pll_sync_q[1];
`else
  assign pll_s = bus.pll_settled;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic active_st;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.radio_on_req) begin
          state_d = S_PLL_WAIT;
        end
      end

      S_PLL_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        // Lock seen on the final count still proceeds to GUARD.
        if (pll_s) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else if (cnt_q == PLL_TO_LAST) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end
      end

      S_GUARD: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!pll_s) begin
          state_d = S_PLL_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = S_READY;
          cnt_d   = '0;
        end
      end

      S_READY: begin
        cnt_d = '0;
        if (!pll_s) begin
          state_d = S_ERR;
        end else if (bus.tx_req) begin
          state_d = S_TX;
        end else if (bus.rx_req) begin
          state_d = S_RX;
        end
      end

      // RX/TX only ever return to READY, so an RX<->TX switch always
      // spends at least one cycle there.
      S_RX: begin
        cnt_d = '0;
        if (!pll_s) begin
          state_d = S_ERR;
        end else if (!bus.rx_req) begin
          state_d = S_READY;
        end
      end

      S_TX: begin
        cnt_d = '0;
        if (!pll_s) begin
          state_d = S_ERR;
        end else if (!bus.tx_req) begin
          state_d = S_READY;
        end
      end

      S_RAMP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == RAMP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_ERR: begin
        cnt_d = '0;
        if (!bus.radio_on_req) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Shutdown overrides every other transition from the active states.
    if (!bus.radio_on_req && active_st) begin
      state_d = S_RAMP;
      cnt_d   = '0;
    end
  end

  always_comb begin
    active_st = 1'b0;
    case (state_q)
      S_PLL_WAIT, S_GUARD, S_READY, S_RX, S_TX: active_st = 1'b1;
      default:                                  active_st = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from next state
  // ---------------------------------------------------------------------------
  always_comb begin
    pll_en_d       = 1'b0;
    radio_enable_d = 1'b0;
    rx_en_d        = 1'b0;
    tx_en_d        = 1'b0;
    busy_d         = (state_d != S_IDLE);
    err_d          = 1'b0;

    case (state_d)
      S_PLL_WAIT, S_GUARD: begin
        pll_en_d = 1'b1;
      end
      S_READY, S_RAMP: begin
        pll_en_d       = 1'b1;
        radio_enable_d = 1'b1;
      end
      S_RX: begin
        pll_en_d       = 1'b1;
        radio_enable_d = 1'b1;
        rx_en_d        = 1'b1;
      end
      S_TX: begin
        pll_en_d       = 1'b1;
        radio_enable_d = 1'b1;
        tx_en_d        = 1'b1;
      end
      S_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        pll_en_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (!srst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pll_en_q       <= 1'b0;
      radio_enable_q <= 1'b0;
      rx_en_q        <= 1'b0;
      tx_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_en_q       <= pll_en_d;
      radio_enable_q <= radio_enable_d;
      rx_en_q        <= rx_en_d;
      tx_en_q        <= tx_en_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
    end
  end

  assign bus.pll_en       = pll_en_q;
  assign bus.radio_enable = radio_enable_q;
  assign bus.radio_rx_en  = rx_en_q;
  assign bus.radio_tx_en  = tx_en_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;
  assign bus.state_o      = state_q;

endmodule
